// File: rtl/led_unit.sv
// rtl/led_unit.sv - PWM driver for a single LED with period-aligned duty shadowing
module led_unit #(
  parameter longint unsigned PERIOD = 1000,
  parameter int              DUTY_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DUTY_W-1:0] counter,
  input  logic              on,
  output logic              led
);

  // Phase counter width; PERIOD=2 still needs one bit.
  localparam int PW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  // Comparison width: wide enough for both phase and duty so nothing truncates.
  localparam int CW = (PW > DUTY_W) ? PW : DUTY_W;
  localparam logic [PW-1:0] LAST_PHASE = PW'(PERIOD - 1);

  logic [PW-1:0]     r_phase;
  logic [DUTY_W-1:0] r_duty_q;
  logic              r_led;

  logic w_high;
  logic w_wrap;

  // A duty at or above PERIOD keeps w_high true for every phase, which gives
  // the clamp-to-always-on behaviour without a special case.
  assign w_high = CW'(r_phase) < CW'(r_duty_q);
  assign w_wrap = (r_phase == LAST_PHASE);

  // Phase counter, shadow duty and registered LED; duty only reloads at wrap
  // (or while disabled) so a period never sees a mid-period duty change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase  <= '0;
      r_duty_q <= '0;
      r_led    <= 1'b0;
    end else if (!on) begin
      r_phase  <= '0;
      r_duty_q <= counter;
      r_led    <= 1'b0;
    end else begin
      r_led <= w_high;
      if (w_wrap) begin
        r_phase  <= '0;
        r_duty_q <= counter;
      end else begin
        r_phase <= r_phase + PW'(1);
      end
    end
  end

  assign led = r_led;

endmodule

// File: tb/tb_led_unit.sv
// tb/tb_led_unit.sv - randomized and directed self-checking bench for led_unit
module tb_led_unit;

  localparam longint P = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] counter = 32'd3;
  logic        on = 1'b0;
  logic        led;
  logic [31:0] counter2 = 32'd250;
  logic        on2 = 1'b0;
  logic        led2;

  int n_checks = 0;
  int n_pass   = 0;
  int hi_cnt   = 0;
  int hi2_cnt  = 0;

  // Reference: position inside the current enabled period and the duty that
  // period was started with; high while position < min(duty, P).
  longint m_pos  = 0;
  longint m_duty = 0;
  logic   m_led  = 1'b0;

  always #5 clk = ~clk;

  led_unit #(.PERIOD(P), .DUTY_W(32)) dut10 (
    .clk(clk), .reset(reset), .counter(counter), .on(on), .led(led)
  );

  led_unit dut1k (
    .clk(clk), .reset(reset), .counter(counter2), .on(on2), .led(led2)
  );

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pos = 0; m_duty = 0; m_led = 1'b0;
    end else if (!on) begin
      m_pos = 0; m_duty = longint'(counter); m_led = 1'b0;
    end else begin
      m_led = (m_pos < ((m_duty < P) ? m_duty : P));
      m_pos = m_pos + 1;
      if (m_pos == P) begin
        m_pos  = 0;
        m_duty = longint'(counter);
      end
    end
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // Advance one cycle; returns at the falling edge with the LED checked.
  task automatic step();
    @(negedge clk);
    check("led_cycle", led, m_led);
    if (led) hi_cnt++;
    if (led2) hi2_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic period_highs(input string tag, input int exp);
    hi_cnt = 0;
    run(int'(P));
    check(tag, hi_cnt, exp);
  endtask

  logic [31:0] picks [0:5];

  initial begin
    picks[0] = 32'd0; picks[1] = 32'd1; picks[2] = 32'd9;
    picks[3] = 32'd10; picks[4] = 32'hFFFF_FFFF; picks[5] = 32'd5;

    // Reset state
    #2;
    check("reset_led", led, 0);
    check("reset_led2", led2, 0);
    run(2);
    reset = 1'b0;
    step();                      // on=0 loads counter=3 into the shadow

    // Basic duty: first edge after on already high, 3 of every 10
    on = 1'b1;
    step();
    check("first_edge_high", led, 1);
    hi_cnt = 1;
    run(int'(P) - 1);
    check("basic_p0", hi_cnt, 3);
    for (int k = 1; k < 5; k++) period_highs("basic_period", 3);

    // Asynchronous reset mid-period
    counter = 32'd5;
    run(1);
    #2 reset = 1'b1;
    #1 check("async_rst_led", led, 0);
    check("async_rst_phase", longint'(dut10.r_phase), 0);
    run(2);
    reset = 1'b0;
    period_highs("post_rst_first", 0);   // shadow was cleared by reset
    period_highs("post_rst_second", 5);

    // Extremes: 0, exactly PERIOD, all ones
    counter = 32'd0;          run(int'(P));
    hi_cnt = 0; run(20);      check("duty_zero", hi_cnt, 0);
    counter = 32'd10;         run(int'(P));
    hi_cnt = 0; run(20);      check("duty_period", hi_cnt, 20);
    counter = 32'hFFFF_FFFF;  run(int'(P));
    hi_cnt = 0; run(20);      check("duty_max", hi_cnt, 20);

    // Mid-period update at phase 4
    counter = 32'd3;          run(int'(P));
    hi_cnt = 0; run(4);
    counter = 32'd7;
    run(6);                   check("midupd_current", hi_cnt, 3);
    period_highs("midupd_next", 7);

    // Enable toggling at phase 2
    counter = 32'd3;          run(int'(P));
    run(2);
    on = 1'b0;
    step();                   check("off_led", led, 0);
    step();                   check("off_phase", longint'(dut10.r_phase), 0);
    counter = 32'd4;
    step();
    on = 1'b1;
    period_highs("reenable", 4);

    // Randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      step();
      if ($urandom_range(0, 15) == 0) counter = picks[$urandom_range(0, 5)];
      if ($urandom_range(0, 31) == 0) counter = 32'($urandom_range(0, 14));
      if ($urandom_range(0, 40) == 0) on = ~on;
      if ($urandom_range(0, 200) == 0) begin
        #2 reset = 1'b1;
        #1 check("rand_async_rst", led, 0);
        #1 reset = 1'b0;
      end
    end

    // Default PERIOD=1000 with duty 250
    on = 1'b0;
    counter = 32'd3;
    step();
    on2 = 1'b1;
    for (int p = 0; p < 40; p++) begin
      hi2_cnt = 0;
      run(1000);
      check("p1000_highs", hi2_cnt, 250);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
